vga_framebuffer_sram: RTL and testbench

VGA_FRAMEBUFFER_SRAM -- requirements
Module: vga_framebuffer_sram

---
 rtl/vga_sram_pkg.sv | 16 +
 rtl/vga_sram_arb.sv | 49 ++++
 rtl/vga_framebuffer_sram.sv | 148 ++++++++++++++
 tb/tb_vga_framebuffer_sram.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sram_pkg.sv
// Shared definitions for the VGA framebuffer SRAM controller: access FSM
// states and the fixed timing constants of one SRAM access.
package vga_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2
    } state_t;

    // Every SRAM access takes PH1 then PH2.
    localparam int SRAM_PHASES  = 2;
    // Accept in cycle T returns readdatavalid in cycle T + READ_LATENCY.
    localparam int READ_LATENCY = SRAM_PHASES + 1;

endpackage

// File: rtl/vga_sram_arb.sv
// Two-port arbiter: the VGA prefetch port (pxl) wins by default, but after
// STARVE_LIMIT consecutive pxl grants against a waiting pro port the next
// slot is handed to pro.
module vga_sram_arb #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic slot,
    input  logic pxl_req,
    input  logic pro_req,
    output logic grant_pxl,
    output logic grant_pro
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt >= CW'(STARVE_LIMIT));

    // Grant selection: pxl first unless pro has been starved long enough.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        grant_pxl = 1'b0;
        grant_pro = 1'b0;
        if (pro_req && (starved || !pxl_req)) begin
            grant_pro = 1'b1;
        end else if (pxl_req) begin
            grant_pxl = 1'b1;
        end
    end

    // Starve counter: counts pxl wins while pro waits, cleared otherwise.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
        if (!sys_rst_n) begin
            starve_cnt <= '0;
        end else if (!pro_req) begin
            starve_cnt <= '0;
        end else if (slot && grant_pro) begin
            starve_cnt <= '0;
        end else if (slot && grant_pxl) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_framebuffer_sram.sv
// Dual-port Avalon-MM front end to an asynchronous 16-bit SRAM. Each access
// runs IDLE/PH2 -> PH1 -> PH2 with all SRAM pins registered; reads return
// data a fixed three cycles after the accept on the originating port.
module vga_framebuffer_sram #(
    parameter int AVN_AW       = 19,
    parameter int AVN_DW       = 16,   // only 16 is supported
    parameter int STARVE_LIMIT = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,

    input  logic                pro_avn_read,
    input  logic                pro_avn_write,
    input  logic [AVN_AW-1:0]   pro_avn_address,
    input  logic [AVN_DW-1:0]   pro_avn_writedata,
    input  logic [AVN_DW/8-1:0] pro_avn_byteenable,
    output logic [AVN_DW-1:0]   pro_avn_readdata,
    output logic                pro_avn_readdatavalid,
    output logic                pro_avn_waitrequest,

    input  logic                pxl_avn_read,
    input  logic                pxl_avn_write,
    input  logic [AVN_AW-1:0]   pxl_avn_address,
    input  logic [AVN_DW-1:0]   pxl_avn_writedata,
    input  logic [AVN_DW/8-1:0] pxl_avn_byteenable,
    output logic [AVN_DW-1:0]   pxl_avn_readdata,
    output logic                pxl_avn_readdatavalid,
    output logic                pxl_avn_waitrequest,

    output logic [AVN_AW-1:0]   sram_addr,
    input  logic [15:0]         sram_dq_in,
    output logic [15:0]         sram_dq_out,
    output logic                sram_dq_oe,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_lb_n,
    output logic                sram_ub_n
);

    import vga_sram_pkg::*;

    state_t              state;
    logic                slot;
    logic                pxl_req;
    logic                pro_req;
    logic                grant_pxl;
    logic                grant_pro;
    logic                accept;
    logic                sel_write;
    logic [AVN_AW-1:0]   sel_addr;
    logic [AVN_DW-1:0]   sel_wdata;
    logic [AVN_DW/8-1:0] sel_be;
    logic                cur_read;
    logic                cur_pro;

    // An accept slot exists in IDLE and PH2; gating with reset keeps both
    // waitrequests high while reset is held.
    assign slot    = sys_rst_n && ((state == IDLE) || (state == PH2));
    assign pxl_req = pxl_avn_read | pxl_avn_write;
    assign pro_req = pro_avn_read | pro_avn_write;
    assign accept  = slot && (grant_pxl || grant_pro);

    assign pxl_avn_waitrequest = !(slot && grant_pxl);
    assign pro_avn_waitrequest = !(slot && grant_pro);

    // Request fields of the granted port; write wins when read is also set.
    assign sel_write = grant_pro ? pro_avn_write      : pxl_avn_write;
    assign sel_addr  = grant_pro ? pro_avn_address    : pxl_avn_address;
    assign sel_wdata = grant_pro ? pro_avn_writedata  : pxl_avn_writedata;
    assign sel_be    = grant_pro ? pro_avn_byteenable : pxl_avn_byteenable;

    vga_sram_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .slot      (slot),
        .pxl_req   (pxl_req),
        .pro_req   (pro_req),
        .grant_pxl (grant_pxl),
        .grant_pro (grant_pro)
    );

    // Access FSM driving registered SRAM pins and the read-return path.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state                 <= IDLE;
            sram_addr             <= '0;
            sram_dq_out           <= '0;
            sram_dq_oe            <= 1'b0;
            sram_ce_n             <= 1'b1;
            sram_oe_n             <= 1'b1;
            sram_we_n             <= 1'b1;
            sram_lb_n             <= 1'b1;
            sram_ub_n             <= 1'b1;
            cur_read              <= 1'b0;
            cur_pro               <= 1'b0;
            pxl_avn_readdata      <= '0;
            pxl_avn_readdatavalid <= 1'b0;
            pro_avn_readdata      <= '0;
            pro_avn_readdatavalid <= 1'b0;
        end else begin
            pxl_avn_readdatavalid <= 1'b0;
            pro_avn_readdatavalid <= 1'b0;

            // End of PH2: the SRAM has driven the word for a full access.
            if (state == PH2 && cur_read) begin
                if (cur_pro) begin
                    pro_avn_readdata      <= sram_dq_in;
                    pro_avn_readdatavalid <= 1'b1;
                end else begin
                    pxl_avn_readdata      <= sram_dq_in;
                    pxl_avn_readdatavalid <= 1'b1;
                end
            end

            if (accept) begin
                state      <= PH1;
                sram_addr  <= sel_addr;
                sram_ce_n  <= 1'b0;
                sram_oe_n  <= sel_write;
                sram_we_n  <= !sel_write;
                sram_dq_oe <= sel_write;
                sram_lb_n  <= sel_write ? !sel_be[0] : 1'b0;
                sram_ub_n  <= sel_write ? !sel_be[1] : 1'b0;
                if (sel_write) begin
                    sram_dq_out <= sel_wdata;
                end
                cur_read   <= !sel_write;
                cur_pro    <= grant_pro;
            end else if (state == PH1) begin
                // Write strobe spans PH1 only; address and data hold in PH2.
                state     <= PH2;
                sram_we_n <= 1'b1;
            end else begin
                state      <= IDLE;
                sram_ce_n  <= 1'b1;
                sram_oe_n  <= 1'b1;
                sram_we_n  <= 1'b1;
                sram_lb_n  <= 1'b1;
                sram_ub_n  <= 1'b1;
                sram_dq_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_framebuffer_sram.sv
// Directed self-checking bench for vga_framebuffer_sram with a behavioural
// asynchronous SRAM model and per-port read-response monitors.
`timescale 1ns/1ps
module tb_vga_framebuffer_sram;

    localparam int AW = 19;
    localparam int DW = 16;

    typedef struct {
        int          c;
        logic [15:0] d;
    } rsp_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;

    logic          pro_avn_read, pro_avn_write;
    logic [AW-1:0] pro_avn_address;
    logic [DW-1:0] pro_avn_writedata;
    logic [1:0]    pro_avn_byteenable;
    logic [DW-1:0] pro_avn_readdata;
    logic          pro_avn_readdatavalid, pro_avn_waitrequest;

    logic          pxl_avn_read, pxl_avn_write;
    logic [AW-1:0] pxl_avn_address;
    logic [DW-1:0] pxl_avn_writedata;
    logic [1:0]    pxl_avn_byteenable;
    logic [DW-1:0] pxl_avn_readdata;
    logic          pxl_avn_readdatavalid, pxl_avn_waitrequest;

    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_in, sram_dq_out;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mem_ready = 1'b0;

    logic [15:0] mem [0:(1<<AW)-1];
    rsp_t pxl_q[$];
    rsp_t pro_q[$];

    vga_framebuffer_sram #(
        .AVN_AW(AW), .AVN_DW(DW), .STARVE_LIMIT(8)
    ) dut (
        .sys_clk               (sys_clk),
        .sys_rst_n             (sys_rst_n),
        .pro_avn_read          (pro_avn_read),
        .pro_avn_write         (pro_avn_write),
        .pro_avn_address       (pro_avn_address),
        .pro_avn_writedata     (pro_avn_writedata),
        .pro_avn_byteenable    (pro_avn_byteenable),
        .pro_avn_readdata      (pro_avn_readdata),
        .pro_avn_readdatavalid (pro_avn_readdatavalid),
        .pro_avn_waitrequest   (pro_avn_waitrequest),
        .pxl_avn_read          (pxl_avn_read),
        .pxl_avn_write         (pxl_avn_write),
        .pxl_avn_address       (pxl_avn_address),
        .pxl_avn_writedata     (pxl_avn_writedata),
        .pxl_avn_byteenable    (pxl_avn_byteenable),
        .pxl_avn_readdata      (pxl_avn_readdata),
        .pxl_avn_readdatavalid (pxl_avn_readdatavalid),
        .pxl_avn_waitrequest   (pxl_avn_waitrequest),
        .sram_addr             (sram_addr),
        .sram_dq_in            (sram_dq_in),
        .sram_dq_out           (sram_dq_out),
        .sram_dq_oe            (sram_dq_oe),
        .sram_ce_n             (sram_ce_n),
        .sram_oe_n             (sram_oe_n),
        .sram_we_n             (sram_we_n),
        .sram_lb_n             (sram_lb_n),
        .sram_ub_n             (sram_ub_n)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Initial SRAM contents: a few hand-picked words over an address pattern.
    function automatic logic [15:0] init_word(input int i);
        if (i == 16)            return 16'hABCD;
        else if (i < 8)         return 16'h1000 + 16'(i);
        else if (i == 'h7FFFF)  return 16'h5A5A;
        else                    return 16'(i) ^ 16'hC3C3;
    endfunction

    // SRAM model: asynchronous read, byte-lane write while we_n is low.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

    always @(negedge sys_clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] = init_word(i);
            mem_ready = 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq_out[15:8];
        end
    end

    // Read-response monitors.
    always @(negedge sys_clk) begin
        if (pxl_avn_readdatavalid) pxl_q.push_back('{cyc, pxl_avn_readdata});
        if (pro_avn_readdatavalid) pro_q.push_back('{cyc, pro_avn_readdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        pro_avn_read = 1'b0; pro_avn_write = 1'b0; pro_avn_address = '0;
        pro_avn_writedata = '0; pro_avn_byteenable = 2'b11;
        pxl_avn_read = 1'b0; pxl_avn_write = 1'b0; pxl_avn_address = '0;
        pxl_avn_writedata = '0; pxl_avn_byteenable = 2'b11;
    endtask

    task automatic test_reset();
        logic [5:0] ctrl;
        idle_inputs();
        sys_rst_n = 1'b0;
        pxl_avn_read = 1'b1;
        pro_avn_write = 1'b1;
        repeat (3) @(negedge sys_clk);
        ctrl = {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe};
        checks++;
        if (ctrl !== 6'b111110) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, 6'b111110);
        end
        checks++;
        if ({sram_addr, sram_dq_out} !== {19'h0, 16'h0}) begin
            errors++; $display("FAIL reset_addr_data: got addr %h dq %h expected 0 0", sram_addr, sram_dq_out);
        end
        checks++;
        if ({pxl_avn_waitrequest, pro_avn_waitrequest} !== 2'b11) begin
            errors++; $display("FAIL reset_waitrequest: got %b expected 11", {pxl_avn_waitrequest, pro_avn_waitrequest});
        end
        checks++;
        if ({pxl_avn_readdatavalid, pro_avn_readdatavalid, pxl_avn_readdata, pro_avn_readdata} !== 34'h0) begin
            errors++; $display("FAIL reset_readpath: got rdv %b%b data %h %h expected all 0",
                pxl_avn_readdatavalid, pro_avn_readdatavalid, pxl_avn_readdata, pro_avn_readdata);
        end
        idle_inputs();
    endtask

    task automatic test_single_read();
        int t0;
        pxl_q.delete(); pro_q.delete();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        pxl_avn_read = 1'b1; pxl_avn_address = 19'h00010;
        @(negedge sys_clk);
        t0 = cyc;
        checks++;
        if ({pxl_avn_waitrequest, pro_avn_waitrequest} !== 2'b01) begin
            errors++; $display("FAIL first_accept_wr: got %b expected 01", {pxl_avn_waitrequest, pro_avn_waitrequest});
        end
        tick(); idle_inputs();
        @(negedge sys_clk);
        checks++;
        if ({sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_lb_n, sram_ub_n} !== {19'h00010, 6'b001000}) begin
            errors++; $display("FAIL read_ph1_pins: got addr %h ce%b oe%b we%b dqoe%b lb%b ub%b", sram_addr,
                sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_lb_n, sram_ub_n);
        end
        tick(); @(negedge sys_clk);
        checks++;
        if ({sram_addr, sram_ce_n, sram_oe_n, sram_we_n, pxl_avn_readdatavalid} !== {19'h00010, 4'b0010}) begin
            errors++; $display("FAIL read_ph2_pins: got addr %h ce%b oe%b we%b rdv%b", sram_addr,
                sram_ce_n, sram_oe_n, sram_we_n, pxl_avn_readdatavalid);
        end
        tick(); @(negedge sys_clk);
        checks++;
        if ({pxl_avn_readdatavalid, pro_avn_readdatavalid, pxl_avn_readdata} !== {2'b10, 16'hABCD}) begin
            errors++; $display("FAIL read_t3: got rdv pxl %b pro %b data %h expected 1 0 abcd",
                pxl_avn_readdatavalid, pro_avn_readdatavalid, pxl_avn_readdata);
        end
        tick(); @(negedge sys_clk);
        checks++;
        if ({pxl_avn_readdatavalid, pxl_avn_readdata} !== {1'b0, 16'hABCD}) begin
            errors++; $display("FAIL read_hold: got rdv %b data %h expected 0 abcd", pxl_avn_readdatavalid, pxl_avn_readdata);
        end
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe} !== 6'b111110) begin
            errors++; $display("FAIL idle_pins: got ce%b oe%b we%b lb%b ub%b dqoe%b expected 111110",
                sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe);
        end
        checks++;
        if (pxl_q.size() != 1 || pro_q.size() != 0 || (pxl_q.size() == 1 && pxl_q[0].c != t0 + 3)) begin
            errors++; $display("FAIL read_latency: got pxl rsp %0d pro rsp %0d expected 1 at cycle %0d",
                pxl_q.size(), pro_q.size(), t0 + 3);
        end
    endtask

    task automatic test_write();
        pxl_q.delete(); pro_q.delete();
        tick();
        pro_avn_write = 1'b1; pro_avn_address = 19'h7FFFF;
        pro_avn_writedata = 16'h1234; pro_avn_byteenable = 2'b10;
        @(negedge sys_clk);
        checks++;
        if ({pxl_avn_waitrequest, pro_avn_waitrequest} !== 2'b10) begin
            errors++; $display("FAIL write_accept_wr: got %b expected 10", {pxl_avn_waitrequest, pro_avn_waitrequest});
        end
        tick(); idle_inputs();
        @(negedge sys_clk);
        checks++;
        if ({sram_addr, sram_dq_out, sram_ce_n, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n} !== {19'h7FFFF, 16'h1234, 5'b00101}) begin
            errors++; $display("FAIL write_ph1_pins: got addr %h dq %h ce%b we%b dqoe%b ub%b lb%b", sram_addr,
                sram_dq_out, sram_ce_n, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n);
        end
        tick(); @(negedge sys_clk);
        checks++;
        if ({sram_addr, sram_dq_out, sram_ce_n, sram_we_n, sram_dq_oe} !== {19'h7FFFF, 16'h1234, 3'b011}) begin
            errors++; $display("FAIL write_ph2_pins: got addr %h dq %h ce%b we%b dqoe%b", sram_addr,
                sram_dq_out, sram_ce_n, sram_we_n, sram_dq_oe);
        end
        tick();
        pro_avn_read = 1'b1; pro_avn_address = 19'h7FFFF;
        tick(); idle_inputs();
        repeat (2) tick();
        @(negedge sys_clk);
        checks++;
        if ({pro_avn_readdatavalid, pro_avn_readdata} !== {1'b1, 16'h125A}) begin
            errors++; $display("FAIL write_readback: got rdv %b data %h expected 1 125a", pro_avn_readdatavalid, pro_avn_readdata);
        end
        tick();
        checks++;
        if (pro_q.size() != 1 || pxl_q.size() != 0) begin
            errors++; $display("FAIL write_no_rdv: got pro rsp %0d pxl rsp %0d expected 1 0", pro_q.size(), pxl_q.size());
        end
    endtask

    task automatic test_rw_both();
        pxl_q.delete(); pro_q.delete();
        tick();
        pxl_avn_read = 1'b1; pxl_avn_write = 1'b1; pxl_avn_address = 19'h00030;
        pxl_avn_writedata = 16'h0F0F; pxl_avn_byteenable = 2'b01;
        tick(); idle_inputs();
        @(negedge sys_clk);
        checks++;
        if ({sram_we_n, sram_oe_n, sram_dq_oe, sram_lb_n, sram_ub_n} !== 5'b01101) begin
            errors++; $display("FAIL rw_both_pins: got we%b oe%b dqoe%b lb%b ub%b expected 01101",
                sram_we_n, sram_oe_n, sram_dq_oe, sram_lb_n, sram_ub_n);
        end
        repeat (5) tick();
        checks++;
        if (mem[19'h00030] !== 16'hC30F || pxl_q.size() != 0) begin
            errors++; $display("FAIL rw_both_result: got mem %h rsp %0d expected c30f 0", mem[19'h00030], pxl_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int acc[8];
        int n = 0;
        int bad = 0;
        pxl_q.delete(); pro_q.delete();
        tick();
        pxl_avn_read = 1'b1; pxl_avn_address = '0;
        for (int k = 0; k < 40 && n < 8; k++) begin
            @(negedge sys_clk);
            if (!pxl_avn_waitrequest) begin
                acc[n] = cyc;
                n++;
            end
            tick();
            if (n == 8) pxl_avn_read = 1'b0;
            else pxl_avn_address = 19'(n);
        end
        idle_inputs();
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL b2b_accepts: got %0d accepts expected 8", n);
        end
        for (int i = 1; i < n; i++) if (acc[i] - acc[i-1] != 2) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL b2b_spacing: got %0d accept gaps not 2 cycles expected 0", bad);
        end
        repeat (6) tick();
        checks++;
        if (pxl_q.size() != 8) begin
            errors++; $display("FAIL b2b_rsp_count: got %0d expected 8", pxl_q.size());
        end
        for (int i = 0; i < 8 && i < pxl_q.size() && i < n; i++) begin
            checks++;
            if (pxl_q[i].d !== 16'h1000 + 16'(i) || pxl_q[i].c != acc[i] + 3) begin
                errors++; $display("FAIL b2b_rsp%0d: got %h at cycle %0d expected %h at cycle %0d",
                    i, pxl_q[i].d, pxl_q[i].c, 16'h1000 + 16'(i), acc[i] + 3);
            end
        end
    endtask

    task automatic test_starvation();
        int grants = 0;
        int n_pro = 0;
        int pattern_bad = 0;
        int both = 0;
        int run = 0;
        int max_run = 0;
        int data_bad = 0;
        pxl_q.delete(); pro_q.delete();
        tick();
        pxl_avn_read = 1'b1; pxl_avn_address = 19'h00100;
        pro_avn_read = 1'b1; pro_avn_address = 19'h00200;
        for (int k = 0; k < 200; k++) begin
            @(negedge sys_clk);
            if (!pxl_avn_waitrequest && !pro_avn_waitrequest) both++;
            if (!pxl_avn_waitrequest || !pro_avn_waitrequest) begin
                if ((!pro_avn_waitrequest) != ((grants % 9) == 8)) pattern_bad++;
                if (!pro_avn_waitrequest) n_pro++;
                grants++;
            end
            if (pro_avn_waitrequest) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        checks++;
        if (grants != 100 || n_pro != 11 || both != 0) begin
            errors++; $display("FAIL starve_counts: got grants %0d pro %0d dual %0d expected 100 11 0", grants, n_pro, both);
        end
        checks++;
        if (pattern_bad != 0) begin
            errors++; $display("FAIL starve_pattern: got %0d grants off the 8 pxl then 1 pro pattern expected 0", pattern_bad);
        end
        checks++;
        if (max_run > 18) begin
            errors++; $display("FAIL starve_wait: got %0d consecutive pro waitrequest cycles expected at most 18", max_run);
        end
        foreach (pxl_q[i]) if (pxl_q[i].d !== 16'hC2C3) data_bad++;
        foreach (pro_q[i]) if (pro_q[i].d !== 16'hC1C3) data_bad++;
        checks++;
        if (pxl_q.size() != 89 || pro_q.size() != 11 || data_bad != 0) begin
            errors++; $display("FAIL starve_rsp: got pxl %0d pro %0d bad data %0d expected 89 11 0",
                pxl_q.size(), pro_q.size(), data_bad);
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        int t1 = -1;
        pxl_q.delete(); pro_q.delete();
        tick();
        pxl_avn_read = 1'b1; pxl_avn_address = 19'h00003;
        pro_avn_write = 1'b1; pro_avn_address = 19'h00020;
        pro_avn_writedata = 16'hBEEF; pro_avn_byteenable = 2'b11;
        @(negedge sys_clk);
        t0 = cyc;
        checks++;
        if ({pxl_avn_waitrequest, pro_avn_waitrequest} !== 2'b01) begin
            errors++; $display("FAIL simul_first: got %b expected 01", {pxl_avn_waitrequest, pro_avn_waitrequest});
        end
        tick(); pxl_avn_read = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (pro_avn_waitrequest !== 1'b1) begin
            errors++; $display("FAIL simul_ph1_wait: got %b expected 1", pro_avn_waitrequest);
        end
        tick(); @(negedge sys_clk);
        if (!pro_avn_waitrequest) t1 = cyc;
        checks++;
        if (t1 - t0 != 2) begin
            errors++; $display("FAIL simul_pro_accept: got offset %0d expected 2", t1 - t0);
        end
        tick(); idle_inputs();
        @(negedge sys_clk);
        checks++;
        if ({pxl_avn_readdatavalid, pxl_avn_readdata, sram_we_n, sram_addr, sram_dq_out} !== {1'b1, 16'h1003, 1'b0, 19'h00020, 16'hBEEF}) begin
            errors++; $display("FAIL simul_overlap: got rdv %b data %h we%b addr %h dq %h", pxl_avn_readdatavalid,
                pxl_avn_readdata, sram_we_n, sram_addr, sram_dq_out);
        end
        repeat (2) tick();
        @(negedge sys_clk);
        checks++;
        if (mem[19'h00020] !== 16'hBEEF || pro_q.size() != 0 || pxl_q.size() != 1) begin
            errors++; $display("FAIL simul_result: got mem %h pro rsp %0d pxl rsp %0d expected beef 0 1",
                mem[19'h00020], pro_q.size(), pxl_q.size());
        end
    endtask

    task automatic test_reset_mid();
        pxl_q.delete(); pro_q.delete();
        tick();
        pxl_avn_read = 1'b1; pxl_avn_address = 19'h00005;
        tick(); idle_inputs();
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, sram_addr} !== {6'b111110, 19'h0}) begin
            errors++; $display("FAIL midreset_pins: got ce%b oe%b we%b lb%b ub%b dqoe%b addr %h", sram_ce_n, sram_oe_n,
                sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, sram_addr);
        end
        checks++;
        if ({pxl_avn_waitrequest, pro_avn_waitrequest, pxl_avn_readdatavalid, pxl_avn_readdata, pro_avn_readdata} !== {3'b110, 32'h0}) begin
            errors++; $display("FAIL midreset_ports: got wr %b%b rdv %b data %h %h", pxl_avn_waitrequest,
                pro_avn_waitrequest, pxl_avn_readdatavalid, pxl_avn_readdata, pro_avn_readdata);
        end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (6) tick();
        checks++;
        if (pxl_q.size() != 0 || pro_q.size() != 0 || sram_ce_n !== 1'b1) begin
            errors++; $display("FAIL midreset_after: got pxl rsp %0d pro rsp %0d ce%b expected 0 0 1",
                pxl_q.size(), pro_q.size(), sram_ce_n);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_rw_both();
        test_back_to_back();
        test_starvation();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
